// File: rtl/multibyte_adder_ctrl_pkg.sv
// Shared definitions for the byte-serial multibyte adder: state encoding,
// byte width and the byte-index width helper.
package multibyte_adder_ctrl_pkg;

  // Width of one datapath slice; the shared adder works on one byte at a time.
  localparam int unsigned BYTE_W = 8;

  // Largest operand width (in bytes) the sequencer is meant to handle.
  localparam int unsigned MAX_NBYTES = 16;

  // Sequencer states; encoding is fixed so other blocks and probes can decode it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Byte index width: clog2 of the byte count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_adder.sv
// Existing 8-bit ripple adder with carry in/out; the only arithmetic used by
// the multibyte sequencer.
module eight_bit_adder
  import multibyte_adder_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in,
  output logic [BYTE_W-1:0] sum,
  output logic              carry_out
);

  logic [BYTE_W:0] total;

  // Widen by one bit so the carry falls out of the top of the addition.
  always_comb begin
    total     = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, carry_in};
    sum       = total[BYTE_W-1:0];
    carry_out = total[BYTE_W];
  end

endmodule

// File: rtl/multibyte_adder_ctrl.sv
// Byte-serial sequencer: adds two NBYTES-wide operands one byte per clock,
// LSB first, through a single shared eight_bit_adder, rippling the carry
// through a register between bytes.
module multibyte_adder_ctrl
  import multibyte_adder_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a_in,
  input  logic [BYTE_W*NBYTES-1:0] b_in,
  input  logic                     carry_in,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     carry_out
);

  localparam int unsigned IdxW = idx_width(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e                         state_q;
  logic [IdxW-1:0]                idx_q;
  logic                           carry_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  b_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  sum_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           cout_q;

  logic [BYTE_W-1:0]              add_a;
  logic [BYTE_W-1:0]              add_b;
  logic [BYTE_W-1:0]              add_sum;
  logic                           add_cout;

  // Present the current operand byte pair to the shared adder; idx_q never
  // leaves 0..NBYTES-1, so the selects stay in range.
  always_comb begin
    add_a = a_q[idx_q];
    add_b = b_q[idx_q];
  end

  eight_bit_adder u_adder (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // Sequencer: accept a request in idle, walk the bytes, pulse done for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-armed below.
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            // Operands are captured here so later input changes cannot
            // disturb an operation in flight.
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= carry_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          sum_q[idx_q] <= add_sum;
          carry_q      <= add_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= add_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // start is deliberately not sampled here; requests are not queued.
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    sum       = sum_q;
    carry_out = cout_q;
  end

endmodule

// File: tb/tb_multibyte_adder_ctrl.sv
// Scoreboard bench for multibyte_adder_ctrl: a 4-byte and a 1-byte instance,
// directed vectors with hand-computed results and done timing.
module tb_multibyte_adder_ctrl;
  import multibyte_adder_ctrl_pkg::*;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start4 = 1'b0;
  logic [31:0] a4 = '0;
  logic [31:0] b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [31:0] sum4;

  logic        start1 = 1'b0;
  logic [7:0]  a1 = '0;
  logic [7:0]  b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1;
  logic [7:0]  sum1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q4[$];
  exp_t q1[$];

  multibyte_adder_ctrl #(.NBYTES(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .a_in      (a4),
    .b_in      (b4),
    .carry_in  (cin4),
    .busy      (busy4),
    .done      (done4),
    .sum       (sum4),
    .carry_out (cout4)
  );

  multibyte_adder_ctrl #(.NBYTES(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .a_in      (a1),
    .b_in      (b1),
    .carry_in  (cin1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 4-byte instance: pops on every done pulse.
  int run4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy4) begin
      run4++;
    end else if (done4) begin
      check("busy4_len", 40'(run4), 40'd4);
      run4 = 0;
      if (q4.size() == 0) begin
        check("done4_unexpected", 40'(done4), 40'd0);
      end else begin
        e = q4.pop_front();
        check("sum4", 40'(sum4), 40'(e.sum));
        check("cout4", 40'(cout4), 40'(e.cout));
        check("done4_cycle", 40'(cyc), 40'(e.cyc));
      end
    end else begin
      run4 = 0;
    end
  end

  // Monitor for the 1-byte instance.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      check("busy1_at_done", 40'(busy1), 40'd0);
      if (q1.size() == 0) begin
        check("done1_unexpected", 40'(done1), 40'd0);
      end else begin
        e = q1.pop_front();
        check("sum1", 40'(sum1), 40'(e.sum));
        check("cout1", 40'(cout1), 40'(e.cout));
        check("done1_cycle", 40'(cyc), 40'(e.cyc));
      end
    end
  end

  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] s, input logic co);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{sum: s, cout: co, cyc: cyc + 4});
    start4 = 1'b0;
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] s, input logic co);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back('{sum: {24'd0, s}, cout: co, cyc: cyc + 1});
    start1 = 1'b0;
  endtask

  task automatic wait_empty4();
    int n = 0;
    while (q4.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      check("timeout4_pending", 40'(q4.size()), 40'd0);
      q4.delete();
    end
    #1;
  endtask

  task automatic wait_empty1();
    int n = 0;
    while (q1.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0) begin
      check("timeout1_pending", 40'(q1.size()), 40'd0);
      q1.delete();
    end
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy4", 40'(busy4), 40'd0);
    check("rst_done4", 40'(done4), 40'd0);
    check("rst_sum4", 40'({cout4, sum4}), 40'd0);
    check("rst_sum1", 40'({cout1, sum1}), 40'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Carry ripple from byte 0 into byte 1.
    issue4(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    wait_empty4();

    // Carry-in propagates through every byte and out the top.
    issue4(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    wait_empty4();

    // start held high: second op accepted only after DONE, using the a_in
    // present at that time; mid-op a_in change must not affect op one.
    a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{sum: 32'h23456789, cout: 1'b0, cyc: cyc + 4});
    q4.push_back('{sum: 32'hBBBBBBBB, cout: 1'b0, cyc: cyc + 10});
    repeat (2) @(posedge clk);
    #1 a4 = 32'hAAAAAAAA;
    repeat (4) @(posedge clk);
    #1 start4 = 1'b0;
    wait_empty4();

    // Reset in the middle of an operation.
    a4 = 32'hFFFFFFFF; b4 = 32'h00000001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 40'(busy4), 40'd0);
    check("midrst_done", 40'(done4), 40'd0);
    check("midrst_sum", 40'({cout4, sum4}), 40'd0);
    check("midrst_state", 40'(u_dut4.state_q), 40'(StIdle));
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("postrst_busy", 40'(busy4), 40'd0);
    issue4(32'd5, 32'd7, 1'b0, 32'd12, 1'b0);
    wait_empty4();

    // Single-byte instance.
    issue1(8'd250, 8'd250, 1'b0, 8'd244, 1'b1);
    wait_empty1();
    issue1(8'd128, 8'd128, 1'b1, 8'd1, 1'b1);
    wait_empty1();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold1", 40'({cout1, sum1}), 40'h101);
    end

    repeat (3) @(posedge clk);
    #1;
    check("q4_drained", 40'(q4.size()), 40'd0);
    check("q1_drained", 40'(q1.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
